volume_level_ctrl: RTL and testbench
====================================

Name: volume_level_ctrl

Overview:
- Owns the 4-bit volume level that drives the LED-bar / 7-segment volume display block.
- Takes raw push-button inputs (up, down, mute) and synchronises and debounces them.
- Applies single-step and hold-to-repeat increments/decrements with saturation, plus mute toggling.
- Sits between the board buttons and the display decoder.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised cycles needed to accept a button level change (10 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000, cycles a direction button must stay held after its first step before auto-repeat starts.
- REPEAT_PERIOD, 10_000_000, cycles between auto-repeat steps.
- MAX_LEVEL, 9, saturation ceiling; legal range 1..15.
- INIT_LEVEL, 0, stored level after reset; must be <= MAX_LEVEL.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_up  in  1  raw button, asynchronous, active-high.
- btn_down  in  1  raw button, asynchronous, active-high.
- btn_mute  in  1  raw button, asynchronous, active-high.
- volume_level  out  4  level to the display block; 0 when muted.
- muted  out  1  mute state.
- level_changed  out  1  one-cycle pulse when volume_level changes value.

Behaviour:
- Reset (async assert, sync release):
  - stored level = INIT_LEVEL; volume_level = INIT_LEVEL; muted = 0; level_changed = 0.
  - FSM = IDLE; all debounced states = 0; all counters = 0.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - Counter resets whenever the synchronised value equals the debounced value.
  - Otherwise the counter increments; on reaching DEBOUNCE_CYCLES-1 the debounced value flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
- Press event: one-cycle pulse on the debounced 0->1 transition. Releases generate no event.
- Step rules:
  - up: level = min(level+1, MAX_LEVEL).
  - down: level = max(level-1, 0).
  - A saturated step changes nothing and produces no pulse.
- Direction FSM, states IDLE, DELAY, REPEAT; registers dir and cnt:
  - IDLE:
    - up press while debounced down=0 -> step up, dir=UP, cnt=0, go DELAY.
    - down press while debounced up=0 -> symmetric, dir=DOWN.
    - up and down presses in the same cycle -> ignored, stay IDLE.
  - DELAY:
    - debounced dir button = 0 -> IDLE.
    - else cnt++; at cnt = REPEAT_DELAY-1 -> step, cnt=0, go REPEAT.
  - REPEAT:
    - debounced dir button = 0 -> IDLE.
    - else cnt++; at cnt = REPEAT_PERIOD-1 -> step, cnt=0.
  - Presses of the opposite direction while in DELAY/REPEAT are ignored. Releasing the held button then returns to IDLE; the other button must be re-pressed to act.
  - Auto-repeat keeps running at saturation; those steps are no-ops.
- Mute:
  - A mute press toggles muted. The stored level is retained.
  - volume_level = muted ? 0 : stored level.
  - While muted, the first up/down press clears muted without changing the stored level and still enters DELAY. Subsequent repeat steps apply normally.
  - Mute press in the same cycle as an up/down press: the mute toggle happens and the direction press is ignored.
- Outputs:
  - volume_level, muted and level_changed are registered.
  - Step/toggle takes effect on the clock edge after the press-event cycle.
  - level_changed = 1 for exactly the cycle in which the new volume_level first appears, only if its value differs from the previous cycle.
  - Unmute with stored level 0 produces no pulse.
- Latency from a raw clean edge to volume_level update: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, tolerance ±1.
- Reset mid-hold: FSM returns to IDLE. A button still held at reset release is only acted on after it has been debounced high again, i.e. it counts as a new press.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, MAX_LEVEL=9, INIT_LEVEL=0):
- Reset, then tap up 3x (each held 10 cycles, released 10) -> volume_level 0->1->2->3, three level_changed pulses, muted=0.
- Hold down with level=3 for 60 cycles -> 3->2 immediately; 20 cycles later ->1; 5 later ->0. Further repeats leave 0 with no pulses. Release -> IDLE.
- From level 8, hold up for 40 cycles -> 9, then saturates. level_changed pulses exactly once.
- 2-cycle glitch on btn_up -> no change. Up and down rising together -> no change.
- At level 5, press mute -> volume_level=0, muted=1, pulse. Press up -> muted=0, volume_level=5, pulse, stored level still 5.
- Hold up past REPEAT_DELAY, assert rst_n=0 mid-repeat -> outputs 0/0/0 immediately. Keep up held through release -> +1 step only after debounce, then repeat after 20 cycles.

Source files
------------

// File: rtl/volume_level_ctrl.sv
// volume_level_ctrl
//   Holds the 4-bit volume level that feeds the LED-bar / 7-segment display
//   decoder. Each raw push button goes through a two-flop synchroniser and a
//   debouncer. Debounced rising edges become one-cycle press events. A
//   three-state FSM (IDLE/DELAY/REPEAT) turns these events into single steps
//   and hold-to-repeat steps. The level saturates at 0 and MAX_LEVEL. The mute
//   button toggles the muted state and leaves the stored level unchanged.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   btn_up        raw up button, asynchronous, active-high
//   btn_down      raw down button, asynchronous, active-high
//   btn_mute      raw mute button, asynchronous, active-high
//   volume_level  registered level to the display; 0 while muted
//   muted         registered mute state
//   level_changed registered one-cycle pulse when volume_level changes value
module volume_level_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter int unsigned MAX_LEVEL       = 9,
  parameter int unsigned INIT_LEVEL      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mute,
  output logic [3:0] volume_level,
  output logic       muted,
  output logic       level_changed
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RD_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST  = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [3:0]       MAX_LVL  = 4'(MAX_LEVEL);
  localparam logic [3:0]       INIT_LVL = 4'(INIT_LEVEL);

  // Bit 0 = up, bit 1 = down, bit 2 = mute.
  logic [2:0] raw, sync1, sync2, deb, deb_d, press;

  assign raw   = {btn_mute, btn_down, btn_up};
  assign press = deb & ~deb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_d <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
    end
  end

  // The counter runs only while the synchronised level differs from the
  // accepted level. A flip therefore needs DEBOUNCE_CYCLES consecutive
  // differing samples.
  for (genvar g = 0; g < 3; g++) begin : g_db
    logic            db_state;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_state <= 1'b0;
        db_cnt   <= '0;
      end else if (sync2[g] == db_state) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_state <= ~db_state;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    assign deb[g] = db_state;
  end

  state_t           state, state_n;
  dir_t             dir, dir_n;
  logic [RPT_W-1:0] cnt, cnt_n;
  logic             step, unmute, dir_held;
  logic [3:0]       level, level_n, vol_n;
  logic             muted_n;

  assign dir_held = (dir == DIR_UP) ? deb[0] : deb[1];

  always_comb begin
    state_n = state;
    dir_n   = dir;
    cnt_n   = cnt;
    step    = 1'b0;
    unmute  = 1'b0;
    case (state)
      IDLE: begin
        // When a mute press arrives in the same cycle, the direction press is
        // dropped. A press is ignored while the opposite button is debounced
        // high. This also covers two presses arriving together.
        if (!press[2]) begin
          if (press[0] && !deb[1]) begin
            dir_n   = DIR_UP;
            cnt_n   = '0;
            state_n = DELAY;
            if (muted) unmute = 1'b1;
            else       step   = 1'b1;
          end else if (press[1] && !deb[0]) begin
            dir_n   = DIR_DOWN;
            cnt_n   = '0;
            state_n = DELAY;
            if (muted) unmute = 1'b1;
            else       step   = 1'b1;
          end
        end
      end
      DELAY: begin
        if (!dir_held) begin
          state_n = IDLE;
        end else if (cnt == RD_LAST) begin
          step    = 1'b1;
          cnt_n   = '0;
          state_n = REPEAT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!dir_held) begin
          state_n = IDLE;
        end else if (cnt == RP_LAST) begin
          step  = 1'b1;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    level_n = level;
    if (step) begin
      if (dir_n == DIR_UP) begin
        if (level < MAX_LVL) level_n = level + 4'd1;
      end else begin
        if (level != 4'd0) level_n = level - 4'd1;
      end
    end
    muted_n = muted;
    if (press[2])    muted_n = ~muted;
    else if (unmute) muted_n = 1'b0;
    vol_n = muted_n ? 4'd0 : level_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dir           <= DIR_UP;
      cnt           <= '0;
      level         <= INIT_LVL;
      muted         <= 1'b0;
      volume_level  <= INIT_LVL;
      level_changed <= 1'b0;
    end else begin
      state         <= state_n;
      dir           <= dir_n;
      cnt           <= cnt_n;
      level         <= level_n;
      muted         <= muted_n;
      volume_level  <= vol_n;
      level_changed <= (vol_n != volume_level);
    end
  end

endmodule

// File: tb/tb_volume_level_ctrl.sv
// Testbench for volume_level_ctrl. A behavioural model runs on every clock
// and is compared each cycle. A table of button segments checks hand-derived
// end states. Hand sequences cover latency and reset during a hold. A random
// phase finishes the run.
module tb_volume_level_ctrl;

  localparam int unsigned D    = 4;
  localparam int unsigned RD   = 20;
  localparam int unsigned RP   = 5;
  localparam int unsigned MAXL = 9;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       btn_up   = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_mute = 1'b0;
  logic [3:0] volume_level;
  logic       muted;
  logic       level_changed;

  always #5 clk = ~clk;

  volume_level_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .MAX_LEVEL      (MAXL),
    .INIT_LEVEL     (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_mute     (btn_mute),
    .volume_level (volume_level),
    .muted        (muted),
    .level_changed(level_changed)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned pulses  = 0;
  int unsigned lat     = 0;

  function automatic void check(string name, int unsigned act, int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void check_range(string name, int unsigned act, int unsigned lo, int unsigned hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
  endfunction

  // Reference model state
  int unsigned m_lvl, m_vol, m_age;
  bit          m_mut, m_chg, m_hold, m_dir_up;
  bit          m_s1u, m_s1d, m_s1m, m_s2u, m_s2d, m_s2m;
  bit          m_debu, m_debd, m_debm, m_pru, m_prd, m_prm;
  logic [31:0] m_hu, m_hd, m_hm;
  int unsigned m_hvu, m_hvd, m_hvm;

  function automatic void model_reset();
    m_lvl = 0; m_vol = 0; m_mut = 0; m_chg = 0; m_hold = 0; m_age = 0; m_dir_up = 1;
    m_s1u = 0; m_s1d = 0; m_s1m = 0; m_s2u = 0; m_s2d = 0; m_s2m = 0;
    m_debu = 0; m_debd = 0; m_debm = 0; m_pru = 0; m_prd = 0; m_prm = 0;
    m_hu = '0; m_hd = '0; m_hm = '0; m_hvu = 0; m_hvd = 0; m_hvm = 0;
  endfunction

  // Accept a new level once the last D synchronised samples all disagree
  // with the currently accepted level.
  function automatic void deb_update(input bit seen, inout bit deb, inout logic [31:0] hist,
                                     inout int unsigned hv, output bit press);
    logic [31:0] mask;
    mask  = (32'd1 << D) - 32'd1;
    press = 1'b0;
    hist  = {hist[30:0], seen};
    if (hv < 32) hv++;
    if (hv >= D && (hist & mask) == (deb ? 32'd0 : mask)) begin
      deb   = !deb;
      press = deb;
      hist  = '0;
      hv    = 0;
    end
  endfunction

  function automatic void model_edge();
    int unsigned lvl, prev;
    bit mut, sup, sdn, held, seen;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lvl = m_lvl; mut = m_mut; prev = m_vol; sup = 0; sdn = 0;
    if (m_prm) mut = !mut;
    if (!m_hold) begin
      if (!m_prm) begin
        if (m_pru && !m_debd) begin
          m_hold = 1; m_dir_up = 1; m_age = 0;
          if (mut) mut = 0; else sup = 1;
        end else if (m_prd && !m_debu) begin
          m_hold = 1; m_dir_up = 0; m_age = 0;
          if (mut) mut = 0; else sdn = 1;
        end
      end
    end else begin
      held = m_dir_up ? m_debu : m_debd;
      if (!held) m_hold = 0;
      else begin
        m_age++;
        if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) begin
          if (m_dir_up) sup = 1; else sdn = 1;
        end
      end
    end
    if (sup && lvl < MAXL) lvl++;
    if (sdn && lvl > 0) lvl--;
    m_lvl = lvl; m_mut = mut;
    m_vol = mut ? 0 : lvl;
    m_chg = (m_vol != prev);
    seen = m_s2u; m_s2u = m_s1u; m_s1u = btn_up;
    deb_update(seen, m_debu, m_hu, m_hvu, m_pru);
    seen = m_s2d; m_s2d = m_s1d; m_s1d = btn_down;
    deb_update(seen, m_debd, m_hd, m_hvd, m_prd);
    seen = m_s2m; m_s2m = m_s1m; m_s1m = btn_mute;
    deb_update(seen, m_debm, m_hm, m_hvm, m_prm);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cyc_vol", volume_level, m_vol);
    check("cyc_muted", muted, m_mut);
    check("cyc_changed", level_changed, m_chg);
    if (level_changed) pulses++;
  endtask

  typedef struct {
    bit          up, dn, mute;
    int unsigned cycles;
    int unsigned vol;
    bit          mut;
    int unsigned npulse;
  } seg_t;

  seg_t segs[$];

  task automatic add(bit up, bit dn, bit mute, int unsigned cycles,
                     int unsigned vol, bit mut, int unsigned npulse);
    seg_t s;
    s.up = up; s.dn = dn; s.mute = mute; s.cycles = cycles;
    s.vol = vol; s.mut = mut; s.npulse = npulse;
    segs.push_back(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned remu, remd, remm;
    model_reset();
    repeat (3) tick();
    check("rst_vol", volume_level, 0);
    check("rst_muted", muted, 0);
    check("rst_changed", level_changed, 0);
    rst_n = 1'b1;

    add(1,0,0,10, 1,0,1); add(0,0,0,10, 1,0,0);
    add(1,0,0,10, 2,0,1); add(0,0,0,10, 2,0,0);
    add(1,0,0,10, 3,0,1); add(0,0,0,10, 3,0,0);
    add(0,1,0,60, 0,0,3); add(0,0,0,15, 0,0,0);
    add(1,0,0,55, 7,0,7); add(0,0,0,15, 8,0,1);
    add(1,0,0,40, 9,0,1); add(0,0,0,15, 9,0,0);
    add(0,1,0, 2, 9,0,0); add(0,0,0,10, 9,0,0);
    add(1,1,0,10, 9,0,0); add(0,0,0,15, 9,0,0);
    add(0,1,0,35, 6,0,3); add(0,0,0,15, 5,0,1);
    add(0,0,1,10, 0,1,1); add(0,0,0,10, 0,1,0);
    add(1,0,0,10, 5,0,1); add(0,0,0,10, 5,0,0);
    add(0,1,0,10, 4,0,1); add(0,0,0,10, 4,0,0);
    add(1,0,1,10, 0,1,1); add(0,0,0,10, 0,1,0);
    add(0,0,1,10, 4,0,1); add(0,0,0,10, 4,0,0);
    add(0,1,0,40, 0,0,4); add(0,0,0,15, 0,0,0);
    add(0,0,1,10, 0,1,0); add(0,0,0,10, 0,1,0);
    add(0,0,1,10, 0,0,0); add(0,0,0,10, 0,0,0);

    for (int i = 0; i < segs.size(); i++) begin
      btn_up = segs[i].up; btn_down = segs[i].dn; btn_mute = segs[i].mute;
      pulses = 0;
      repeat (segs[i].cycles) tick();
      check($sformatf("seg%0d_vol", i), volume_level, segs[i].vol);
      check($sformatf("seg%0d_muted", i), muted, segs[i].mut);
      check($sformatf("seg%0d_pulses", i), pulses, segs[i].npulse);
    end

    // Press latency from a clean raw edge, then reset in the middle of repeat.
    btn_up = 1'b1;
    lat = 0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (volume_level == 4'd1) begin lat = n; break; end
    end
    check_range("press_latency", lat, 6, 8);
    repeat (25) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_vol", volume_level, 0);
    check("async_rst_muted", muted, 0);
    check("async_rst_changed", level_changed, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    lat = 0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (volume_level == 4'd1) begin lat = n; break; end
    end
    check_range("held_after_reset_latency", lat, 6, 8);
    lat = 0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (volume_level == 4'd2) begin lat = n; break; end
    end
    check("repeat_delay_after_reset", lat, RD);
    btn_up = 1'b0;
    repeat (15) tick();

    remu = 0; remd = 0; remm = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
      end
      if (remu == 0) begin btn_up = 1'($urandom_range(0, 1)); remu = $urandom_range(1, 60); end
      else remu--;
      if (remd == 0) begin btn_down = 1'($urandom_range(0, 1)); remd = $urandom_range(1, 60); end
      else remd--;
      if (remm == 0) begin btn_mute = ($urandom_range(0, 3) == 0); remm = $urandom_range(1, 20); end
      else remm--;
      tick();
    end
    btn_up = 1'b0; btn_down = 1'b0; btn_mute = 1'b0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
